// File: rtl/seq_comparator_pkg.sv
// Shared types and helpers for the multi-cycle magnitude comparator.
package seq_comparator_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Width of the chunk counter / cycles field: must hold values 0..nchunk.
  function automatic int unsigned cnt_width(input int unsigned nchunk);
    return $clog2(nchunk + 1);
  endfunction

endpackage

// File: rtl/seq_comparator_if.sv
// Start/busy/done handshake and operand/result bundle for seq_comparator.
interface seq_comparator_if
  import seq_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = cnt_width(NCHUNK);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic             eq;
  logic             lt;
  logic             gt;
  logic [CW-1:0]    cycles;

  modport master (
    output start, is_signed, x, y,
    input  busy, done, eq, lt, gt, cycles
  );

  modport slave (
    input  start, is_signed, x, y,
    output busy, done, eq, lt, gt, cycles
  );

endinterface

// File: rtl/seq_comparator_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module chunk_cmp #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             c_lt,
  output logic             c_gt
);

  assign c_lt = (a < b);
  assign c_gt = (a > b);

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per clock with early exit.
module seq_comparator
  import seq_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic           clk,
  input  logic           reset,
  seq_comparator_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = cnt_width(NCHUNK);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] xs, ys, xs_nx, ys_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [CW-1:0]    cycles_q, cycles_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;
  logic             eq_q, eq_nx;
  logic             lt_q, lt_nx;
  logic             gt_q, gt_nx;

  logic             c_lt, c_gt;
  logic             differ;
  logic             last;

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a    (xs[WIDTH-1 -: CHUNK]),
    .b    (ys[WIDTH-1 -: CHUNK]),
    .c_lt (c_lt),
    .c_gt (c_gt)
  );

  assign differ = c_lt | c_gt;
  assign last   = (cnt == CW'(NCHUNK - 1));

  // State register plus datapath/result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      xs       <= '0;
      ys       <= '0;
      cnt      <= '0;
      cycles_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      xs       <= xs_nx;
      ys       <= ys_nx;
      cnt      <= cnt_nx;
      cycles_q <= cycles_nx;
      busy_q   <= busy_nx;
      done_q   <= done_nx;
      eq_q     <= eq_nx;
      lt_q     <= lt_nx;
      gt_q     <= gt_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start)      state_nx = S_RUN;
      S_RUN:   if (differ || last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath and result next values; results hold unless a compare finishes.
  always_comb begin
    xs_nx     = xs;
    ys_nx     = ys;
    cnt_nx    = cnt;
    cycles_nx = cycles_q;
    busy_nx   = busy_q;
    done_nx   = 1'b0;
    eq_nx     = eq_q;
    lt_nx     = lt_q;
    gt_nx     = gt_q;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          xs_nx   = bus.is_signed ? (bus.x ^ MSB_MASK) : bus.x;
          ys_nx   = bus.is_signed ? (bus.y ^ MSB_MASK) : bus.y;
          cnt_nx  = '0;
          busy_nx = 1'b1;
        end
      end
      S_RUN: begin
        if (differ) begin
          eq_nx     = 1'b0;
          lt_nx     = c_lt;
          gt_nx     = c_gt;
          done_nx   = 1'b1;
          busy_nx   = 1'b0;
          cycles_nx = cnt + CW'(1);
        end else if (last) begin
          eq_nx     = 1'b1;
          lt_nx     = 1'b0;
          gt_nx     = 1'b0;
          done_nx   = 1'b1;
          busy_nx   = 1'b0;
          cycles_nx = CW'(NCHUNK);
        end else begin
          xs_nx  = xs << CHUNK;
          ys_nx  = ys << CHUNK;
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        busy_nx = 1'b0;
      end
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.eq     = eq_q;
  assign bus.lt     = lt_q;
  assign bus.gt     = gt_q;
  assign bus.cycles = cycles_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Directed self-checking bench for seq_comparator in 8/2 and 2/1 configurations.
module tb_seq_comparator;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_comparator_if #(.WIDTH(8), .CHUNK(2)) b8 ();
  seq_comparator_if #(.WIDTH(2), .CHUNK(1)) b2 ();

  seq_comparator #(.WIDTH(8), .CHUNK(2)) u_dut8 (.clk(clk), .reset(reset), .bus(b8));
  seq_comparator #(.WIDTH(2), .CHUNK(1)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge; holds start for exactly one edge.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic s);
    b8.x = a; b8.y = b; b8.is_signed = s; b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
  endtask

  task automatic go2(input logic [1:0] a, input logic [1:0] b, input logic s);
    b2.x = a; b2.y = b; b2.is_signed = s; b2.start = 1'b1;
    @(posedge clk); #1;
    b2.start = 1'b0;
  endtask

  // Edges counted after the accepting edge until done is seen; -1 on timeout.
  task automatic wait8(output int lat);
    lat = -1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (b8.done) begin lat = i; break; end
    end
  endtask

  task automatic wait2(output int lat);
    lat = -1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (b2.done) begin lat = i; break; end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    reset = 1'b1;
    b8.start = 1'b0; b8.is_signed = 1'b0; b8.x = '0; b8.y = '0;
    b2.start = 1'b0; b2.is_signed = 1'b0; b2.x = '0; b2.y = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_busy",   32'(b8.busy), 32'd0);
    check("rst_done",   32'(b8.done), 32'd0);
    check("rst_res",    32'({b8.eq, b8.lt, b8.gt}), 32'b000);
    check("rst_cycles", 32'(b8.cycles), 32'd0);

    // Equal operands run all four chunks.
    go8(8'hA5, 8'hA5, 1'b0);
    check("eq_busy", 32'(b8.busy), 32'd1);
    wait8(lat);
    check("eq_lat",    32'(lat), 32'd4);
    check("eq_res",    32'({b8.eq, b8.lt, b8.gt}), 32'b100);
    check("eq_cycles", 32'(b8.cycles), 32'd4);
    check("eq_busy_done", 32'(b8.busy), 32'd0);
    @(posedge clk); #1;
    check("eq_pulse",  32'(b8.done), 32'd0);
    check("eq_hold",   32'({b8.eq, b8.lt, b8.gt}), 32'b100);

    // MSB chunk differs: unsigned then signed.
    go8(8'h80, 8'h7F, 1'b0);
    wait8(lat);
    check("u80_lat",    32'(lat), 32'd1);
    check("u80_res",    32'({b8.eq, b8.lt, b8.gt}), 32'b001);
    check("u80_cycles", 32'(b8.cycles), 32'd1);
    @(posedge clk); #1;
    go8(8'h80, 8'h7F, 1'b1);
    wait8(lat);
    check("s80_lat",    32'(lat), 32'd1);
    check("s80_res",    32'({b8.eq, b8.lt, b8.gt}), 32'b010);
    check("s80_cycles", 32'(b8.cycles), 32'd1);
    @(posedge clk); #1;

    // Last chunk differs, then a back-to-back start in the done cycle.
    go8(8'h13, 8'h12, 1'b0);
    wait8(lat);
    check("l13_lat", 32'(lat), 32'd4);
    check("l13_res", 32'({b8.eq, b8.lt, b8.gt}), 32'b001);
    go8(8'h12, 8'h13, 1'b0);
    check("b2b_busy", 32'(b8.busy), 32'd1);
    check("b2b_done", 32'(b8.done), 32'd0);
    check("b2b_hold", 32'({b8.eq, b8.lt, b8.gt}), 32'b001);
    wait8(lat);
    check("b2b_lat",    32'(lat), 32'd4);
    check("b2b_res",    32'({b8.eq, b8.lt, b8.gt}), 32'b010);
    check("b2b_cycles", 32'(b8.cycles), 32'd4);
    @(posedge clk); #1;

    // Start while busy is ignored and operands are not resampled.
    go8(8'h01, 8'h00, 1'b0);
    @(posedge clk); #1;
    b8.x = 8'hFF; b8.y = 8'h00; b8.start = 1'b1;
    @(posedge clk); #1;
    b8.start = 1'b0;
    wait8(lat);
    check("ign_lat",    32'((lat < 0) ? lat : lat + 2), 32'd4);
    check("ign_res",    32'({b8.eq, b8.lt, b8.gt}), 32'b001);
    check("ign_cycles", 32'(b8.cycles), 32'd4);
    @(posedge clk); #1;

    // Reset in the middle of a compare clears everything, no done follows.
    go8(8'h55, 8'h55, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("mrst_busy", 32'(b8.busy), 32'd0);
    check("mrst_done", 32'(b8.done), 32'd0);
    check("mrst_res",  32'({b8.eq, b8.lt, b8.gt}), 32'b000);
    check("mrst_cyc",  32'(b8.cycles), 32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (b8.done || b8.busy) pulses++;
    end
    check("mrst_quiet", 32'(pulses), 32'd0);

    // WIDTH=2, CHUNK=1 configuration.
    go2(2'd3, 2'd1, 1'b0);
    wait2(lat);
    check("w2_gt_lat", 32'(lat), 32'd1);
    check("w2_gt_res", 32'({b2.eq, b2.lt, b2.gt}), 32'b001);
    go2(2'd1, 2'd3, 1'b0);
    wait2(lat);
    check("w2_lt_lat", 32'(lat), 32'd1);
    check("w2_lt_res", 32'({b2.eq, b2.lt, b2.gt}), 32'b010);
    go2(2'd1, 2'd1, 1'b0);
    wait2(lat);
    check("w2_eq_lat", 32'(lat), 32'd2);
    check("w2_eq_res", 32'({b2.eq, b2.lt, b2.gt}), 32'b100);
    check("w2_eq_cyc", 32'(b2.cycles), 32'd2);
    // Signed: 1 > -2.
    go2(2'd1, 2'd2, 1'b1);
    wait2(lat);
    check("w2_s_lat", 32'(lat), 32'd1);
    check("w2_s_res", 32'({b2.eq, b2.lt, b2.gt}), 32'b001);
    check("w2_s_cyc", 32'(b2.cycles), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
